// File: rtl/fifo_push_ctrl_pkg.sv
// ============================================================================
//  Module   : fifo_push_ctrl_pkg
//  Purpose  : Shared state encoding and byte-count constants for fifo_push_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_push_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUSH_LO = 2'd1,
    PUSH_HI = 2'd2
  } state_e;

  localparam logic NBYTES_ONE = 1'b0;
  localparam logic NBYTES_TWO = 1'b1;

endpackage : fifo_push_ctrl_pkg

`default_nettype wire

// File: rtl/fifo_push_ctrl.sv
// ============================================================================
//  Module   : fifo_push_ctrl
//  Purpose  : Serialises 1/2-byte words into async-FIFO write strobes, with a
//             stall watchdog that drops a word if the FIFO stays full too long.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_push_ctrl
  import fifo_push_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int STALL_LIMIT = 255,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [2*DATA_WIDTH-1:0] IN_DATA,
  input  logic                    IN_NBYTES,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic                    W_FULL,
  output logic                    W_INC,
  output logic [DATA_WIDTH-1:0]   WR_DATA,
  output logic                    DROP_ERR,
  input  logic                    ERR_CLR
);

  localparam logic [CNT_WIDTH-1:0] STALL_LAST = CNT_WIDTH'(STALL_LIMIT - 1);

  state_e                  state_q, state_d;
  logic [2*DATA_WIDTH-1:0] hold_q, hold_d;
  logic                    nbytes_q, nbytes_d;
  logic [CNT_WIDTH-1:0]    stall_q, stall_d;
  logic                    drop_err_q, drop_err_d;
  logic                    drop_set;
  logic                    push_active;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      nbytes_q   <= NBYTES_ONE;
      stall_q    <= '0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      nbytes_q   <= nbytes_d;
      stall_q    <= stall_d;
      drop_err_q <= drop_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    nbytes_d = nbytes_q;
    stall_d  = stall_q;
    drop_set = 1'b0;

    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          hold_d   = IN_DATA;
          nbytes_d = IN_NBYTES;
          stall_d  = '0;
          state_d  = PUSH_LO;
        end
      end

      PUSH_LO, PUSH_HI: begin
        if (!W_FULL) begin
          stall_d = '0;
          if (state_q == PUSH_LO && nbytes_q == NBYTES_TWO) begin
            state_d = PUSH_HI;
          end else begin
            state_d = IDLE;
          end
        end else if (stall_q == STALL_LAST) begin
          // Watchdog expiry: abandon the rest of the word; bytes already
          // written stay in the FIFO.
          state_d  = IDLE;
          stall_d  = '0;
          drop_set = 1'b1;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        stall_d = '0;
      end
    endcase

    // A new drop outranks a simultaneous clear.
    if (drop_set) begin
      drop_err_d = 1'b1;
    end else if (ERR_CLR) begin
      drop_err_d = 1'b0;
    end else begin
      drop_err_d = drop_err_q;
    end
  end

  assign push_active = (state_q == PUSH_LO) || (state_q == PUSH_HI);
  assign IN_READY    = (state_q == IDLE);
  assign W_INC       = push_active & ~W_FULL;
  assign DROP_ERR    = drop_err_q;

  always_comb begin
    WR_DATA = '0;
    case (state_q)
      PUSH_LO: WR_DATA = hold_q[DATA_WIDTH-1:0];
      PUSH_HI: WR_DATA = hold_q[2*DATA_WIDTH-1:DATA_WIDTH];
      default: WR_DATA = '0;
    endcase
  end

endmodule : fifo_push_ctrl

`default_nettype wire

// File: tb/tb_fifo_push_ctrl.sv
// ============================================================================
//  Module   : tb_fifo_push_ctrl
//  Purpose  : Self-checking bench for fifo_push_ctrl (default and short-watchdog
//             instances sharing one stimulus).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_push_ctrl;

  logic        CLK;
  logic        RST;
  logic [15:0] IN_DATA;
  logic        IN_NBYTES;
  logic        IN_VALID;
  logic        W_FULL;
  logic        ERR_CLR;

  logic        rdy_a, winc_a, drop_a;
  logic [7:0]  wr_a;
  logic        rdy_b, winc_b, drop_b;
  logic [7:0]  wr_b;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_push_ctrl dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_NBYTES(IN_NBYTES),
    .IN_VALID(IN_VALID), .IN_READY(rdy_a), .W_FULL(W_FULL), .W_INC(winc_a),
    .WR_DATA(wr_a), .DROP_ERR(drop_a), .ERR_CLR(ERR_CLR)
  );

  fifo_push_ctrl #(.STALL_LIMIT(4)) dut_wd (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_NBYTES(IN_NBYTES),
    .IN_VALID(IN_VALID), .IN_READY(rdy_b), .W_FULL(W_FULL), .W_INC(winc_b),
    .WR_DATA(wr_b), .DROP_ERR(drop_b), .ERR_CLR(ERR_CLR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [15:0] data;
    logic        nb;
    logic        valid;
    logic        wf;
    logic        clr;
    logic        e_rdy;
    logic        e_winc;
    logic [7:0]  e_wr;
    logic        e_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [15:0] data, input logic nb,
                     input logic valid, input logic wf, input logic clr,
                     input logic e_rdy, input logic e_winc, input logic [7:0] e_wr,
                     input logic e_drop);
    vec_t v;
    v.rst = rst; v.data = data; v.nb = nb; v.valid = valid; v.wf = wf; v.clr = clr;
    v.e_rdy = e_rdy; v.e_winc = e_winc; v.e_wr = e_wr; v.e_drop = e_drop;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sample in the middle of the cycle; next edge follows.
  task automatic check_a(input string tag, input logic e_rdy, input logic e_winc,
                         input logic [7:0] e_wr, input logic e_drop);
    chk({tag, ".IN_READY"}, {7'd0, rdy_a}, {7'd0, e_rdy});
    chk({tag, ".W_INC"},    {7'd0, winc_a}, {7'd0, e_winc});
    chk({tag, ".WR_DATA"},  wr_a, e_wr);
    chk({tag, ".DROP_ERR"}, {7'd0, drop_a}, {7'd0, e_drop});
  endtask

  task automatic check_b(input string tag, input logic e_rdy, input logic e_winc,
                         input logic [7:0] e_wr, input logic e_drop);
    chk({tag, ".IN_READY"}, {7'd0, rdy_b}, {7'd0, e_rdy});
    chk({tag, ".W_INC"},    {7'd0, winc_b}, {7'd0, e_winc});
    chk({tag, ".WR_DATA"},  wr_b, e_wr);
    chk({tag, ".DROP_ERR"}, {7'd0, drop_b}, {7'd0, e_drop});
  endtask

  task automatic drive(input logic rst, input logic [15:0] data, input logic nb,
                       input logic valid, input logic wf, input logic clr);
    RST = rst; IN_DATA = data; IN_NBYTES = nb; IN_VALID = valid; W_FULL = wf; ERR_CLR = clr;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    //   rst data     nb valid wf clr | rdy winc wr    drop
    // 1-byte word
    add(0, 16'hA55A, 0, 1, 0, 0,   1, 0, 8'h00, 0);
    add(0, 16'hA55A, 0, 0, 0, 0,   0, 1, 8'h5A, 0);
    add(0, 16'h0000, 0, 0, 0, 0,   1, 0, 8'h00, 0);
    // back-to-back 2-byte words, 3-cycle period
    add(0, 16'h1234, 1, 1, 0, 0,   1, 0, 8'h00, 0);
    add(0, 16'h1234, 1, 1, 0, 0,   0, 1, 8'h34, 0);
    add(0, 16'h1234, 1, 1, 0, 0,   0, 1, 8'h12, 0);
    add(0, 16'h1234, 1, 1, 0, 0,   1, 0, 8'h00, 0);
    add(0, 16'h1234, 1, 0, 0, 0,   0, 1, 8'h34, 0);
    add(0, 16'h1234, 1, 0, 0, 0,   0, 1, 8'h12, 0);
    // 2-byte word, 5 stall cycles after the low byte
    add(0, 16'h1234, 1, 1, 0, 0,   1, 0, 8'h00, 0);
    add(0, 16'h0000, 0, 0, 0, 0,   0, 1, 8'h34, 0);
    for (int i = 0; i < 5; i++)
      add(0, 16'h0000, 0, 0, 1, 0, 0, 0, 8'h12, 0);
    add(0, 16'h0000, 0, 0, 0, 0,   0, 1, 8'h12, 0);
    add(0, 16'h0000, 0, 0, 0, 0,   1, 0, 8'h00, 0);
    // new word offered while busy is ignored
    add(0, 16'hBEEF, 1, 1, 0, 0,   1, 0, 8'h00, 0);
    add(0, 16'h1357, 0, 1, 1, 0,   0, 0, 8'hEF, 0);
    add(0, 16'h1357, 0, 1, 0, 0,   0, 1, 8'hEF, 0);
    add(0, 16'h0000, 0, 0, 0, 0,   0, 1, 8'hBE, 0);
    add(0, 16'h0000, 0, 0, 0, 0,   1, 0, 8'h00, 0);
    // reset in PUSH_HI while full
    add(0, 16'hCAFE, 1, 1, 0, 0,   1, 0, 8'h00, 0);
    add(0, 16'h0000, 0, 0, 0, 0,   0, 1, 8'hFE, 0);
    add(1, 16'h0000, 0, 0, 1, 0,   0, 0, 8'hCA, 0);
    add(0, 16'h0000, 0, 0, 1, 0,   1, 0, 8'h00, 0);
    add(0, 16'h0000, 0, 0, 0, 0,   1, 0, 8'h00, 0);

    do_reset();
    @(negedge CLK);
    check_a("reset_a", 1, 0, 8'h00, 0);
    check_b("reset_b", 1, 0, 8'h00, 0);
    next_cycle();

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].data, vecs[k].nb, vecs[k].valid, vecs[k].wf, vecs[k].clr);
      @(negedge CLK);
      check_a($sformatf("vec%0d", k), vecs[k].e_rdy, vecs[k].e_winc, vecs[k].e_wr, vecs[k].e_drop);
      next_cycle();
    end

    // Watchdog on the STALL_LIMIT=4 instance
    do_reset();
    drive(0, 16'h5566, 1, 1, 1, 0);
    @(negedge CLK);
    check_b("wd_accept", 1, 0, 8'h00, 0);
    next_cycle();
    drive(0, 16'h0000, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check_b($sformatf("wd_stall%0d", i), 0, 0, 8'h66, 0);
      next_cycle();
    end
    @(negedge CLK);
    check_b("wd_dropped", 1, 0, 8'h00, 1);
    next_cycle();
    @(negedge CLK);
    check_b("wd_sticky", 1, 0, 8'h00, 1);
    next_cycle();
    drive(0, 16'h0000, 0, 0, 1, 1);
    @(negedge CLK);
    check_b("wd_clr_pending", 1, 0, 8'h00, 1);
    next_cycle();
    drive(0, 16'h0000, 0, 0, 1, 0);
    @(negedge CLK);
    check_b("wd_cleared", 1, 0, 8'h00, 0);
    next_cycle();

    // Drop with ERR_CLR held high: the set must win
    drive(0, 16'h7788, 0, 1, 1, 1);
    next_cycle();
    drive(0, 16'h0000, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) next_cycle();
    drive(0, 16'h0000, 0, 0, 0, 0);
    @(negedge CLK);
    check_b("wd_set_wins", 1, 0, 8'h00, 1);
    next_cycle();

    // 1-byte word through the short-watchdog instance, no stall
    drive(0, 16'h00C3, 0, 1, 0, 0);
    next_cycle();
    drive(0, 16'h0000, 0, 0, 0, 0);
    @(negedge CLK);
    check_b("wd_1byte", 0, 1, 8'hC3, 1);
    next_cycle();
    @(negedge CLK);
    check_b("wd_idle", 1, 0, 8'h00, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_fifo_push_ctrl

`default_nettype wire
